// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path.
// Holds the default counter widths, the supported oversampling ratios,
// the index of the last bit in a frame and a small majority helper used
// by the data sampler's three-sample voter.
package uart_rx_pkg;

  localparam int PRESC_W   = 6;
  localparam int BIT_CNT_W = 4;

  // Supported oversampling ratios.
  localparam logic [PRESC_W-1:0] PRESC_8  = 6'd8;
  localparam logic [PRESC_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESC_W-1:0] PRESC_32 = 6'd32;

  // Start + 8 data + parity + stop: bit_cnt reaches this on the stop bit.
  localparam int FRAME_LAST_BIT = 10;

  // 2-out-of-3 vote; a single glitched sample is outvoted.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_data_sampler_if.sv
// Signal bundle between the RX FSM side and the data sampler.
// master: RX line source / FSM side (drives RX_IN, Prescale and the enables,
//         observes the synchronized line, counters and the voted bit).
// slave : the sampler itself.
// Signals:
//   RX_IN       raw serial line, idle high, asynchronous to CLK
//   Prescale    oversampling ratio
//   cnt_en      edge/bit counter enable
//   dat_samp_en sampling enable
//   rx_sync     synchronized RX_IN
//   edge_cnt    oversampling edge index within the current bit
//   bit_cnt     bit index within the frame (0 = start bit)
//   sampled_bit majority-voted bit value
//   samp_done   one-cycle pulse with each sampled_bit update
interface rx_data_sampler_if #(
  parameter int PRESC_W   = uart_rx_pkg::PRESC_W,
  parameter int BIT_CNT_W = uart_rx_pkg::BIT_CNT_W
) ();

  logic                 RX_IN;
  logic [PRESC_W-1:0]   Prescale;
  logic                 cnt_en;
  logic                 dat_samp_en;
  logic                 rx_sync;
  logic [PRESC_W-1:0]   edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic                 sampled_bit;
  logic                 samp_done;

  modport master (
    output RX_IN, Prescale, cnt_en, dat_samp_en,
    input  rx_sync, edge_cnt, bit_cnt, sampled_bit, samp_done
  );

  modport slave (
    input  RX_IN, Prescale, cnt_en, dat_samp_en,
    output rx_sync, edge_cnt, bit_cnt, sampled_bit, samp_done
  );

endinterface

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and frame bit counter.
// Ports:
//   CLK         oversampling clock
//   RST         asynchronous, active-low reset
//   cntEn_i     count enable; when low both counters clear on every clock
//   prescale_i  oversampling ratio (edges per bit)
//   edgeCnt_o   edge index within the current bit, 0 .. prescale_i-1
//   bitCnt_o    bit index within the frame, saturating at all-ones
module edge_bit_counter #(
  parameter int PRESC_W   = uart_rx_pkg::PRESC_W,
  parameter int BIT_CNT_W = uart_rx_pkg::BIT_CNT_W
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 cntEn_i,
  input  logic [PRESC_W-1:0]   prescale_i,
  output logic [PRESC_W-1:0]   edgeCnt_o,
  output logic [BIT_CNT_W-1:0] bitCnt_o
);

  logic [PRESC_W-1:0]   edgeCnt_q, edgeCnt_d;
  logic [BIT_CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic [PRESC_W-1:0]   lastEdge;

  assign lastEdge = prescale_i - PRESC_W'(1);

  // Counter state registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edgeCnt_q <= '0;
      bitCnt_q  <= '0;
    end else begin
      edgeCnt_q <= edgeCnt_d;
      bitCnt_q  <= bitCnt_d;
    end
  end

  // Dropping the enable abandons the frame, so both counters restart from
  // zero. The bit counter sticks at all-ones so a stuck-enabled FSM can
  // never make a late bit look like the start bit again.
  always_comb begin
    edgeCnt_d = edgeCnt_q;
    bitCnt_d  = bitCnt_q;
    if (!cntEn_i) begin
      edgeCnt_d = '0;
      bitCnt_d  = '0;
    end else if (edgeCnt_q == lastEdge) begin
      edgeCnt_d = '0;
      if (bitCnt_q != '1) begin
        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
      end
    end else begin
      edgeCnt_d = edgeCnt_q + PRESC_W'(1);
    end
  end

  assign edgeCnt_o = edgeCnt_q;
  assign bitCnt_o  = bitCnt_q;

endmodule

// File: rtl/rx_data_sampler.sv
// UART RX front end: synchronizes the raw line, runs the oversampling
// edge/bit counters and majority-votes three samples around each bit centre.
// Ports:
//   CLK   oversampling clock
//   RST   asynchronous, active-low reset
//   bus   rx_data_sampler_if slave modport (line, Prescale, enables in;
//         rx_sync, edge_cnt, bit_cnt, sampled_bit, samp_done out)
// Parameters:
//   SYNC_STAGES  synchronizer depth (2 or 3)
//   PRESC_W      width of Prescale and edge_cnt
//   BIT_CNT_W    width of bit_cnt
module rx_data_sampler #(
  parameter int SYNC_STAGES = 2,
  parameter int PRESC_W     = uart_rx_pkg::PRESC_W,
  parameter int BIT_CNT_W   = uart_rx_pkg::BIT_CNT_W
) (
  input logic               CLK,
  input logic               RST,
  rx_data_sampler_if.slave  bus
);

  import uart_rx_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxSync;
  logic [PRESC_W-1:0]     edgeCnt;
  logic [BIT_CNT_W-1:0]   bitCnt;
  logic [PRESC_W-1:0]     mid, midM1, midP1;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic                   sampledBit_q, sampledBit_d;
  logic                   sampDone_q, sampDone_d;

  // Line synchronizer. Flops reset to the idle-high level so a reset never
  // fabricates a start edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.RX_IN};
    end
  end

  assign rxSync = sync_q[SYNC_STAGES-1];

  edge_bit_counter #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) uEdgeBitCounter (
    .CLK        (CLK),
    .RST        (RST),
    .cntEn_i    (bus.cnt_en),
    .prescale_i (bus.Prescale),
    .edgeCnt_o  (edgeCnt),
    .bitCnt_o   (bitCnt)
  );

  // Sample points straddle the bit centre: MID-1, MID, MID+1.
  assign mid   = bus.Prescale >> 1;
  assign midM1 = mid - PRESC_W'(1);
  assign midP1 = mid + PRESC_W'(1);

  // Voter registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      sampledBit_q <= 1'b1;
      sampDone_q   <= 1'b0;
    end else begin
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      sampledBit_q <= sampledBit_d;
      sampDone_q   <= sampDone_d;
    end
  end

  // The third sample is taken live from rxSync and voted in the same cycle,
  // so the result is visible from MID+2, well before the deserializer
  // captures at the last edge of the bit.
  always_comb begin
    s0_d         = s0_q;
    s1_d         = s1_q;
    sampledBit_d = sampledBit_q;
    sampDone_d   = 1'b0;
    if (bus.dat_samp_en) begin
      if (edgeCnt == midM1) begin
        s0_d = rxSync;
      end
      if (edgeCnt == mid) begin
        s1_d = rxSync;
      end
      if (edgeCnt == midP1) begin
        sampledBit_d = majority3(s0_q, s1_q, rxSync);
        sampDone_d   = 1'b1;
      end
    end
  end

  assign bus.rx_sync     = rxSync;
  assign bus.edge_cnt    = edgeCnt;
  assign bus.bit_cnt     = bitCnt;
  assign bus.sampled_bit = sampledBit_q;
  assign bus.samp_done   = sampDone_q;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Self-checking bench for rx_data_sampler.
// Each bit is described by the three values the synchronized line must show
// at MID-1, MID and MID+1; the line is driven SYNC cycles early so the
// synchronizer output lines up. The expected vote is queued when the cycle
// that triggers it is driven and popped when samp_done is seen.
module tb_rx_data_sampler;

  import uart_rx_pkg::*;

  localparam int SYNC = 2;
  localparam int BIT_SAT = (1 << BIT_CNT_W) - 1;

  typedef struct {
    logic bitVal;
    int   idx;
  } exp_t;

  logic CLK = 1'b0;
  logic RST;

  rx_data_sampler_if #(.PRESC_W(PRESC_W), .BIT_CNT_W(BIT_CNT_W)) bus ();

  rx_data_sampler #(
    .SYNC_STAGES (SYNC),
    .PRESC_W     (PRESC_W),
    .BIT_CNT_W   (BIT_CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int       assertCount = 0;
  int       failCount   = 0;
  int       curPresc    = 8;
  logic     holdVal     = 1'b1;
  logic [2:0] triples [64];
  logic     frameBits [16];
  exp_t     sbQ [$];

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic vote(input logic [2:0] t);
    int ones;
    ones = int'(t[2]) + int'(t[1]) + int'(t[0]);
    return (ones >= 2);
  endfunction

  function automatic int satBit(input int b);
    return (b > BIT_SAT) ? BIT_SAT : b;
  endfunction

  // Value the synchronized line must carry at counting cycle k.
  function automatic logic lineAt(input int k);
    int b, e, m;
    logic [2:0] t;
    b = k / curPresc;
    e = k % curPresc;
    m = curPresc / 2;
    if (b > 63) b = 63;
    t = triples[b];
    if (e == m - 1) return t[2];
    if (e == m)     return t[1];
    if (e == m + 1) return t[0];
    return vote(t);
  endfunction

  function automatic void fillTriples(input logic [2:0] t);
    for (int i = 0; i < 64; i++) triples[i] = t;
  endfunction

  // Two idle cycles with cnt_en low, then n counting cycles. Counters are
  // checked after every counting cycle.
  task automatic applyStimulus(input int n, input logic dse);
    for (int j = -SYNC; j < n; j++) begin
      bus.RX_IN       = lineAt(j + SYNC);
      bus.cnt_en      = (j >= 0);
      bus.dat_samp_en = dse;
      if (j >= 0 && dse && (j % curPresc) == curPresc / 2 + 1) begin
        int b;
        b = j / curPresc;
        sbQ.push_back('{vote(triples[(b > 63) ? 63 : b]), satBit(b)});
      end
      @(posedge CLK);
      @(negedge CLK);
      if (j >= 0) begin
        checkOutput("edgeCnt", 32'(bus.edge_cnt), (j + 1) % curPresc);
        checkOutput("bitCnt", 32'(bus.bit_cnt), satBit((j + 1) / curPresc));
        if (!dse) checkOutput("sampHold", 32'(bus.sampled_bit), 32'(holdVal));
      end
    end
  endtask

  task automatic dropCntEn();
    bus.cnt_en = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checkOutput("clrEdge", 32'(bus.edge_cnt), 0);
    checkOutput("clrBit", 32'(bus.bit_cnt), 0);
  endtask

  task automatic setPrescale(input logic [PRESC_W-1:0] p);
    bus.Prescale = p;
    curPresc     = int'(p);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_rxSync"}, 32'(bus.rx_sync), 1);
    checkOutput({tag, "_edge"}, 32'(bus.edge_cnt), 0);
    checkOutput({tag, "_bit"}, 32'(bus.bit_cnt), 0);
    checkOutput({tag, "_sampled"}, 32'(bus.sampled_bit), 1);
    checkOutput({tag, "_done"}, 32'(bus.samp_done), 0);
  endtask

  // Scoreboard consumer: every samp_done pulse must match a queued vote.
  always @(negedge CLK) begin
    if (RST === 1'b1 && bus.samp_done === 1'b1) begin
      checkOutput("votePending", 32'(sbQ.size() > 0), 1);
      if (sbQ.size() > 0) begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("sampledBit", 32'(bus.sampled_bit), 32'(e.bitVal));
        checkOutput("voteBitCnt", 32'(bus.bit_cnt), e.idx);
        checkOutput("voteEdge", 32'(bus.edge_cnt), curPresc / 2 + 2);
        if (e.idx < 16) frameBits[e.idx] = bus.sampled_bit;
      end
    end
  end

  initial begin
    logic [7:0]  frameByte;
    logic [10:0] frame;
    logic [7:0]  data;

    RST             = 1'b0;
    bus.RX_IN       = 1'b1;
    bus.cnt_en      = 1'b0;
    bus.dat_samp_en = 1'b0;
    setPrescale(PRESC_8);
    fillTriples(3'b111);
    for (int i = 0; i < 16; i++) frameBits[i] = 1'bx;

    repeat (3) @(negedge CLK);
    checkResetState("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Sampling disabled over a low bit: vote must hold at its reset value.
    $display("[TB] dat_samp_en low, line low");
    fillTriples(3'b000);
    holdVal = 1'b1;
    applyStimulus(12, 1'b0);
    dropCntEn();

    // Prescale 8, line constantly low.
    $display("[TB] Prescale 8, constant low");
    applyStimulus(17, 1'b1);
    dropCntEn();

    // Prescale 16: single glitch outvoted, then a 0,0,1 pattern.
    $display("[TB] Prescale 16, glitch voting");
    setPrescale(PRESC_16);
    fillTriples(3'b111);
    triples[0] = 3'b101;
    triples[1] = 3'b001;
    applyStimulus(16 + 11, 1'b1);
    dropCntEn();

    // Prescale 32: full frame 0x5A, even parity, LSB first.
    $display("[TB] Prescale 32, frame 0x5A");
    setPrescale(PRESC_32);
    data  = 8'h5A;
    frame = {1'b1, ^data, data, 1'b0};
    fillTriples(3'b111);
    for (int i = 0; i <= FRAME_LAST_BIT; i++) begin
      triples[i] = {3{frame[i]}};
    end
    applyStimulus(FRAME_LAST_BIT * 32 + 16 + 3, 1'b1);
    @(negedge CLK);
    for (int i = 0; i < 8; i++) frameByte[i] = frameBits[i + 1];
    checkOutput("frameStart", 32'(frameBits[0]), 0);
    checkOutput("frameData", 32'(frameByte), 32'h5A);
    checkOutput("frameParity", 32'(frameBits[9]), 0);
    checkOutput("frameStop", 32'(frameBits[FRAME_LAST_BIT]), 1);
    dropCntEn();

    // Prescale 8 for 40 bit periods: bit counter saturates.
    $display("[TB] bit counter saturation");
    setPrescale(PRESC_8);
    fillTriples(3'b111);
    applyStimulus(40 * 8, 1'b1);
    checkOutput("satBit", 32'(bus.bit_cnt), BIT_SAT);
    dropCntEn();

    // Asynchronous reset mid-frame at edge 5 of bit 3.
    $display("[TB] reset mid-frame");
    fillTriples(3'b000);
    applyStimulus(3 * 8 + 5, 1'b1);
    checkOutput("preRstSampled", 32'(bus.sampled_bit), 0);
    #2 RST = 1'b0;
    #1 checkResetState("asyncRst");
    repeat (3) @(negedge CLK);
    checkResetState("holdRst");
    bus.RX_IN  = 1'b1;
    bus.cnt_en = 1'b0;
    RST        = 1'b1;
    repeat (2) @(negedge CLK);

    checkOutput("sbEmpty", 32'(sbQ.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
